rx_sync_sample_counter: RTL and testbench

//  Downstream consumer of sync_rx from the multi-board master control. Aligns the sync request
//  to the RX sample grid (rx_sample_strobe), emits a one-sample-aligned sync pulse, and runs a

---
 rtl/rx_sync_sample_counter.sv | 119 +++++++++++
 tb/tb_rx_sync_sample_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sync_sample_counter.sv
// rx_sync_sample_counter
// Aligns the master-control sync request to the RX sample grid, emits a
// single aligned sync pulse and runs the shared sample counter that every
// board in a master/slave chain uses to timestamp samples identically.
// Also drives a stretched sync_out towards slave boards.
module rx_sync_sample_counter #(
  parameter int CNT_W   = 32,
  parameter int STRETCH = 4    // sync_out high time in master_clk cycles (1..255)
) (
  input  logic             master_clk,
  input  logic             reset,
  input  logic             sync_rx,
  input  logic             enable_rx,
  input  logic             rx_sample_strobe,
  input  logic             master_en,
  output logic [CNT_W-1:0] sample_count,
  output logic             sync_pulse,
  output logic             synced,
  output logic             count_wrapped,
  output logic [7:0]       resync_count,
  output logic             sync_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [7:0]       STRETCH_M1 = 8'(STRETCH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       sync_d;
  logic       sync_edge;
  logic       align;
  logic       count_step;
  logic [7:0] stretch_cnt;

  // Rising edge of the level request; sync_d resets high so a request held
  // through reset release is not mistaken for a new edge.
  assign sync_edge = sync_rx & ~sync_d;

  // The alignment strobe must arrive while already ARMED, so a strobe in the
  // same cycle as the arming edge is never used.
  assign align      = enable_rx & (state == ST_ARMED) & rx_sample_strobe;
  assign count_step = enable_rx & (state == ST_RUN)   & rx_sample_strobe;

  // Next-state logic; dropping enable_rx overrides every other event.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (!enable_rx) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (sync_edge)        state_nxt = ST_ARMED;
        ST_ARMED: if (rx_sample_strobe) state_nxt = ST_RUN;
        ST_RUN:   if (sync_edge)        state_nxt = ST_ARMED;
        default:                        state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, edge-detect history and the registered synced flag.
  // NOTE: asynchronous reset in the sensitivity list; every flop here has a reset value.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sync_d <= 1'b1;
      synced <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      state  <= state_nxt;
      sync_d <= sync_rx;
      synced <= (state_nxt == ST_RUN);
    end
  end

  // Sample counter, aligned-sync pulse, wrap flag and resync statistics.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      sample_count  <= '0;
      sync_pulse    <= 1'b0;
      count_wrapped <= 1'b0;
      resync_count  <= 8'd0;
    end else begin
      sync_pulse <= align;
      if (align) begin
        sample_count  <= '0;
        count_wrapped <= 1'b0;
        if (resync_count != 8'hFF) resync_count <= resync_count + 8'd1;
      end else if (count_step) begin
        sample_count <= sample_count + 1'b1;
        if (sample_count == CNT_MAX) count_wrapped <= 1'b1;
      end
    end
  end

  // Stretched sync towards slave boards; a new edge restarts the full
  // stretch and master_en low clears it on the next cycle.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      stretch_cnt <= 8'd0;
      sync_out    <= 1'b0;
    end else if (!master_en) begin
      stretch_cnt <= 8'd0;
      sync_out    <= 1'b0;
    end else if (sync_edge) begin
      stretch_cnt <= STRETCH_M1;
      sync_out    <= 1'b1;
    end else if (stretch_cnt != 8'd0) begin
      stretch_cnt <= stretch_cnt - 8'd1;
      sync_out    <= 1'b1;
    end else begin
      sync_out    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_sync_sample_counter.sv
// tb_rx_sync_sample_counter
// Scoreboard bench: the driver applies inputs on the falling edge and pushes
// the outputs a behavioural model predicts for after the next rising edge;
// an independent monitor pops and compares just after each rising edge.
module tb_rx_sync_sample_counter;

  localparam int CNT_W   = 4;
  localparam int STRETCH = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             master_clk;
  logic             reset;
  logic             sync_rx;
  logic             enable_rx;
  logic             rx_sample_strobe;
  logic             master_en;
  logic [CNT_W-1:0] sample_count;
  logic             sync_pulse;
  logic             synced;
  logic             count_wrapped;
  logic [7:0]       resync_count;
  logic             sync_out;

  rx_sync_sample_counter #(.CNT_W(CNT_W), .STRETCH(STRETCH)) dut (
    .master_clk       (master_clk),
    .reset            (reset),
    .sync_rx          (sync_rx),
    .enable_rx        (enable_rx),
    .rx_sample_strobe (rx_sample_strobe),
    .master_en        (master_en),
    .sample_count     (sample_count),
    .sync_pulse       (sync_pulse),
    .synced           (synced),
    .count_wrapped    (count_wrapped),
    .resync_count     (resync_count),
    .sync_out         (sync_out)
  );

  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  typedef struct {
    int count;
    bit pulse;
    bit synced;
    bit wrapped;
    int resync;
    bit sout;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: "waiting for an alignment strobe" and "running" flags,
  // a modulo counter, and sync_out derived from how long ago the last
  // qualifying edge happened and whether master_en stayed high since.
  int m_count, m_resync, m_t, m_last_edge, m_last_off;
  bit m_pulse, m_wrapped, m_sout, m_prev_sync, m_waiting, m_running;

  task automatic model_step(input bit rst, input bit s, input bit en,
                            input bit stb, input bit men);
    bit edge_now;
    if (rst) begin
      m_count = 0; m_resync = 0; m_pulse = 0; m_wrapped = 0; m_sout = 0;
      m_prev_sync = 1; m_waiting = 0; m_running = 0;
      m_last_edge = -1000; m_last_off = -1000;
    end else begin
      edge_now    = s && !m_prev_sync;
      m_prev_sync = s;
      if (edge_now && men) m_last_edge = m_t;
      if (!men)            m_last_off  = m_t;
      m_sout  = ((m_t - m_last_edge) < STRETCH) && (m_last_off < m_last_edge);
      m_pulse = 0;
      if (!en) begin
        m_waiting = 0;
        m_running = 0;
      end else if (m_waiting && stb) begin
        m_count   = 0;
        m_pulse   = 1;
        m_wrapped = 0;
        m_resync  = (m_resync < 255) ? m_resync + 1 : 255;
        m_waiting = 0;
        m_running = 1;
      end else begin
        if (m_running && stb) begin
          m_count = (m_count + 1) % CNT_MOD;
          if (m_count == 0) m_wrapped = 1;
        end
        if (edge_now) begin
          m_waiting = 1;
          m_running = 0;
        end
      end
    end
    m_t++;
  endtask

  // Apply one cycle of stimulus and queue the predicted response.
  task automatic drive(input bit rst, input bit s, input bit en,
                       input bit stb, input bit men);
    exp_t e;
    @(negedge master_clk);
    reset            = rst;
    sync_rx          = s;
    enable_rx        = en;
    rx_sample_strobe = stb;
    master_en        = men;
    model_step(rst, s, en, stb, men);
    e.count   = m_count;
    e.pulse   = m_pulse;
    e.synced  = m_running;
    e.wrapped = m_wrapped;
    e.resync  = m_resync;
    e.sout    = m_sout;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge master_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sample_count",  int'(sample_count),  e.count);
        check("sync_pulse",    int'(sync_pulse),    int'(e.pulse));
        check("synced",        int'(synced),        int'(e.synced));
        check("count_wrapped", int'(count_wrapped), int'(e.wrapped));
        check("resync_count",  int'(resync_count),  e.resync);
        check("sync_out",      int'(sync_out),      int'(e.sout));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit s, en, stb, men, rst;
    int wait_cycles;
    reset = 1'b1; sync_rx = 1'b1; enable_rx = 1'b0;
    rx_sample_strobe = 1'b0; master_en = 1'b0;
    m_t = 0;
    model_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset with sync_rx high, release: no edge, stays idle, sync_out low.
    repeat (3) drive(1, 1, 0, 0, 1);
    repeat (4) drive(0, 1, 1, 1, 1);
    drive(0, 0, 1, 0, 1);
    // Edge at n, strobes at n+3 and n+7.
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 1, 1);
    repeat (3) drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 1, 1);
    drive(0, 0, 1, 0, 1);
    // Edge coincident with strobe, next strobe five cycles later.
    drive(0, 1, 1, 1, 1);
    repeat (4) drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 1, 1);
    // Nineteen strobes in RUN: wrap past 15.
    for (int i = 0; i < 19; i++) drive(0, 1, 1, 1, 1);
    // Re-sync clears the wrap flag; edges two cycles apart restart stretch.
    drive(0, 0, 1, 0, 1);
    drive(0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 1);
    drive(0, 1, 1, 0, 1);
    repeat (6) drive(0, 1, 1, 0, 1);
    // Stretch cut short by master_en low.
    drive(0, 0, 1, 0, 1);
    drive(0, 1, 1, 0, 1);
    drive(0, 1, 1, 0, 0);
    repeat (3) drive(0, 1, 1, 0, 1);
    // Count a few samples, then drop enable_rx together with a strobe.
    for (int i = 0; i < 9; i++) drive(0, 1, 1, 1, 1);
    drive(0, 1, 0, 1, 1);
    repeat (3) drive(0, 1, 0, 1, 1);
    // Mid-operation reset.
    drive(0, 0, 1, 0, 1);
    drive(0, 1, 1, 1, 1);
    drive(0, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 1);
    drive(0, 1, 1, 1, 1);

    // Randomized phases: fast-toggling sync alternating with long runs.
    s = 1;
    for (int i = 0; i < 4000; i++) begin
      bit slow;
      slow = ((i / 400) % 2) == 1;
      rst  = ($urandom_range(0, 799) == 0);
      if (slow) begin
        if ($urandom_range(0, 99) == 0) s = ~s;
        en = ($urandom_range(0, 299) != 0);
      end else begin
        if ($urandom_range(0, 5) == 0) s = ~s;
        en = ($urandom_range(0, 99) < 94);
      end
      stb = ($urandom_range(0, 1) == 0);
      men = ($urandom_range(0, 19) != 0);
      drive(rst, s, en, stb, men);
    end

    // Let the monitor consume the last predictions (bounded wait).
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge master_clk);
      wait_cycles++;
    end
    @(posedge master_clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
